// File: rtl/gate_stream_reducer.sv
// Burst reducer: folds LEN operand words through one selectable two-input gate,
// bit by bit, and presents the WIDTH-bit result on a valid/ready output stream.
module gate_stream_reducer #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             err,
    output logic [1:0]       dbg_state
);

    // Handshakes: a word moves on either stream only in a cycle where both
    // valid and ready are high at the rising edge; in_ready and out_valid are
    // registered and never depend combinationally on the partner's signal.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] out_data_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             err_q;

    logic             start_ok;
    logic             beat;
    logic             last_beat;
    logic             invert;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] result_d;
    logic [LEN_W-1:0] count_d;

    always_comb begin
        start_ok = (len != '0) && (len <= LEN_W'(MAX_LEN)) && (op <= OP_XNOR);
        beat     = in_valid && in_ready_q;

        merged = acc_q ^ in_data;
        case (op_q)
            OP_AND, OP_NAND: merged = acc_q & in_data;
            OP_OR,  OP_NOR:  merged = acc_q | in_data;
            default:         merged = acc_q ^ in_data;
        endcase

        // The first beat seeds the accumulator so no identity value is needed.
        acc_d     = (count_q == '0) ? in_data : merged;
        count_d   = count_q + LEN_W'(1);
        last_beat = (count_d == len_q);

        invert   = (op_q == OP_NAND) || (op_q == OP_NOR) || (op_q == OP_XNOR);
        result_d = invert ? ~acc_d : acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            len_q       <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            op_q       <= op;
                            len_q      <= len;
                            count_q    <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= S_ACC;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        if (last_beat) begin
                            // Inversion happens once, on the finished reduction.
                            out_data_q  <= result_d;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_stream_reducer.sv
// Bench for gate_stream_reducer: directed vector table, error/reset sequences,
// and random bursts scored against a column-counting reference model.
module tb_gate_stream_reducer;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef struct {
        logic [2:0]       op;
        int               len;
        logic [WIDTH-1:0] beats [MAX_LEN];
        logic [WIDTH-1:0] exp;
        int               gap;
        int               hold;
        bit               pulse;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = '0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             err;
    logic [1:0]       dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] exp_q[$];
    vec_t vecs[$];

    gate_stream_reducer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a result leaves at the next rising edge whenever both are high here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                check("sb_out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // Reference: per bit column, count ones across the burst and apply the gate rule.
    function automatic logic [WIDTH-1:0] ref_reduce(input logic [2:0] g, input int n,
                                                    input logic [WIDTH-1:0] b [MAX_LEN]);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < WIDTH; k++) begin
            int ones;
            logic bitv;
            ones = 0;
            for (int i = 0; i < n; i++) ones += int'(b[i][k]);
            case (g)
                3'd0, 3'd2: bitv = (ones == n);
                3'd1, 3'd3: bitv = (ones > 0);
                default:    bitv = (ones % 2 == 1);
            endcase
            if (g == 3'd2 || g == 3'd3 || g == 3'd5) bitv = !bitv;
            r[k] = bitv;
        end
        return r;
    endfunction

    task automatic add_vec(input logic [2:0] g, input int n, input logic [WIDTH-1:0] b0,
                           input logic [WIDTH-1:0] b1, input logic [WIDTH-1:0] b2,
                           input logic [WIDTH-1:0] fill, input logic [WIDTH-1:0] e,
                           input int gap, input int hold, input bit pulse);
        vec_t v;
        v.op = g; v.len = n; v.exp = e; v.gap = gap; v.hold = hold; v.pulse = pulse;
        for (int i = 0; i < MAX_LEN; i++) v.beats[i] = fill;
        v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2;
        vecs.push_back(v);
    endtask

    // Entered #1 after a rising edge with the DUT idle; returns #1 after the
    // output handshake edge, i.e. in the first IDLE cycle.
    task automatic run_burst(input vec_t v);
        exp_q.push_back(v.exp);
        start = 1'b1; op = v.op; len = LEN_W'(v.len);
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom_range(0, 7)); len = LEN_W'($urandom_range(0, 31));
        check("acc_busy", busy, 1);
        check("acc_in_ready", in_ready, 1);
        check("acc_out_valid", out_valid, 0);
        for (int i = 0; i < v.len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    in_valid = 1'b0; in_data = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1; in_data = v.beats[i];
            check("beat_in_ready", in_ready, 1);
            @(posedge clk); #1;
            if (i < v.len - 1) check("early_out_valid", out_valid, 0);
        end
        in_valid = 1'b0; in_data = 8'($urandom);
        check("latency_out_valid", out_valid, 1);
        check("result_out_data", out_data, v.exp);
        check("out_in_ready", in_ready, 0);
        for (int h = 0; h < v.hold; h++) begin
            if (v.pulse && h == 1) begin start = 1'b1; op = 3'd1; len = LEN_W'(2); in_valid = 1'b1; end
            if (v.pulse && h == 3) begin start = 1'b1; op = 3'd0; len = '0; in_valid = 1'b1; end
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b0;
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, v.exp);
            check("hold_in_ready", in_ready, 0);
            check("hold_err", err, 0);
            check("hold_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_busy", busy, 0);
        check("post_out_data_kept", out_data, v.exp);
    endtask

    task automatic reject_start(input logic [2:0] g, input logic [LEN_W-1:0] n);
        start = 1'b1; op = g; len = n;
        @(posedge clk); #1;
        start = 1'b0;
        check("reject_err", err, 1);
        check("reject_busy", busy, 0);
        check("reject_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("reject_err_cleared", err, 0);
        check("reject_idle_busy", busy, 0);
    endtask

    initial begin
        vec_t v;
        add_vec(3'd3, 2,  8'h0F, 8'h20, 8'h00, 8'h00, 8'hD0, 0, 2, 1'b0);
        add_vec(3'd0, 3,  8'hFF, 8'hF0, 8'h3C, 8'h00, 8'h30, 0, 0, 1'b0);
        add_vec(3'd4, 3,  8'hAA, 8'h0F, 8'hFF, 8'h00, 8'h5A, 1, 0, 1'b0);
        add_vec(3'd5, 1,  8'hA5, 8'h00, 8'h00, 8'h00, 8'h5A, 0, 1, 1'b0);
        add_vec(3'd2, 16, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0, 0, 1'b0);
        add_vec(3'd1, 16, 8'h01, 8'h02, 8'h04, 8'h00, 8'h07, 0, 0, 1'b0);
        add_vec(3'd3, 3,  8'h01, 8'h02, 8'h04, 8'h00, 8'hF8, 0, 5, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_burst(vecs[i]);

        reject_start(3'd0, LEN_W'(0));
        reject_start(3'd6, LEN_W'(4));
        reject_start(3'd1, LEN_W'(MAX_LEN + 1));

        // Reset two beats into a four-beat burst: nothing may be presented.
        start = 1'b1; op = 3'd4; len = LEN_W'(4);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", err, 0);
        check("midrst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("after_rst_out_valid", out_valid, 0);
        check("after_rst_busy", busy, 0);

        v = vecs[0];
        v.op = 3'd1; v.len = 2; v.beats[0] = 8'h01; v.beats[1] = 8'h80;
        v.exp = 8'h81; v.gap = 3; v.hold = 0; v.pulse = 1'b0;
        run_burst(v);

        for (int r = 0; r < 40; r++) begin
            v.op = 3'($urandom_range(0, 5));
            v.len = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < MAX_LEN; i++) v.beats[i] = 8'($urandom);
            v.gap = $urandom_range(0, 2);
            v.hold = $urandom_range(0, 3);
            v.pulse = 1'b0;
            v.exp = ref_reduce(v.op, v.len, v.beats);
            run_burst(v);
        end

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
